// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: phase-increment sweep (chirp) generator feeding an nco phi_inc_i input.
// Steps the increment from a start value to a stop value in fixed steps. Each value is held
// for a programmable number of clken cycles. The sweep can optionally repeat.
//
// Optional feature: define SWEEP_TRIANGLE_EN to add the tri_i input and a DOWN state. With
// tri_i set at start, the sweep runs up to stop and then back down to start.
//
// Ports:
//   clk          nco clock
//   reset_n      asynchronous active-low reset
//   clken        clock enable shared with the nco; low freezes all sequencing
//   start_i      one-cycle start request, honoured only in IDLE
//   abort_i      one-cycle abort, honoured in any state; wins over start_i
//   repeat_i     sampled at start; restart from phi_start after reaching stop
//   tri_i        (SWEEP_TRIANGLE_EN only) sampled at start; triangle sweep
//   phi_start_i  first increment, sampled at start
//   phi_stop_i   last increment, sampled at start
//   phi_step_i   step size (nonzero), sampled at start
//   dwell_i      clken cycles each value is held (0 behaves as 1), sampled at start
//   phi_inc_o    registered increment to the nco
//   busy_o       high while a sweep is active
//   step_o       one-cycle pulse when phi_inc_o takes a new value
//   done_o       one-cycle pulse at the end of a non-repeating sweep
//   err_o        one-cycle pulse when a start request is rejected
module nco_sweep_ctrl #(
   parameter int unsigned PHW     = 32,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clken,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic               repeat_i,
`ifdef SWEEP_TRIANGLE_EN
   input  logic               tri_i,
`endif
   input  logic [PHW-1:0]     phi_start_i,
   input  logic [PHW-1:0]     phi_stop_i,
   input  logic [PHW-1:0]     phi_step_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [PHW-1:0]     phi_inc_o,
   output logic               busy_o,
   output logic               step_o,
   output logic               done_o,
   output logic               err_o
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
`ifdef SWEEP_TRIANGLE_EN
      StDown,
`endif
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [PHW-1:0]       phi_inc_q, phi_inc_d;
   logic [PHW-1:0]       start_q, start_d;
   logic [PHW-1:0]       stop_q, stop_d;
   logic [PHW-1:0]       step_q, step_d;
   logic                 repeat_q, repeat_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 step_pulse_q, step_pulse_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
`ifdef SWEEP_TRIANGLE_EN
   logic                 tri_q, tri_d;
   logic [PHW:0]         dn_diff;
   logic [PHW-1:0]       dn_next;
`endif

   logic [PHW:0]         up_sum;
   logic [PHW-1:0]       up_next;
   logic [DWELL_W-1:0]   dwell_ld;
   logic                 hold_end;

   // One extra bit keeps the carry, so a sum that wraps past 2^PHW still clamps to stop.
   always_comb begin
      up_sum  = {1'b0, phi_inc_q} + {1'b0, step_q};
      up_next = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[PHW-1:0];
   end

`ifdef SWEEP_TRIANGLE_EN
   // A borrow in the top bit means the difference went below zero; clamp to start.
   always_comb begin
      dn_diff = {1'b0, phi_inc_q} - {1'b0, step_q};
      dn_next = (dn_diff[PHW] || (dn_diff[PHW-1:0] <= start_q)) ? start_q : dn_diff[PHW-1:0];
   end
`endif

   assign dwell_ld = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
   assign hold_end = clken && (cnt_q == DWELL_W'(1));

   always_comb begin
      state_d      = state_q;
      phi_inc_d    = phi_inc_q;
      start_d      = start_q;
      stop_d       = stop_q;
      step_d       = step_q;
      repeat_d     = repeat_q;
      dwell_d      = dwell_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      step_pulse_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      tri_d        = tri_q;
`endif

      if (abort_i) begin
         state_d = StIdle;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  if ((phi_step_i == '0) || (phi_start_i > phi_stop_i)) begin
                     err_d = 1'b1;
                  end else begin
                     start_d      = phi_start_i;
                     stop_d       = phi_stop_i;
                     step_d       = phi_step_i;
                     repeat_d     = repeat_i;
                     dwell_d      = dwell_ld;
                     cnt_d        = dwell_ld;
`ifdef SWEEP_TRIANGLE_EN
                     tri_d        = tri_i;
`endif
                     phi_inc_d    = phi_start_i;
                     step_pulse_d = 1'b1;
                     busy_d       = 1'b1;
                     state_d      = StRun;
                  end
               end
            end

            StRun: begin
               if (clken) begin
                  if (hold_end) begin
                     cnt_d = dwell_q;
                     if (phi_inc_q != stop_q) begin
                        phi_inc_d    = up_next;
                        step_pulse_d = 1'b1;
                     end else
`ifdef SWEEP_TRIANGLE_EN
                     // A single-point triangle has nothing to descend through.
                     if (tri_q && (stop_q != start_q)) begin
                        phi_inc_d    = dn_next;
                        step_pulse_d = 1'b1;
                        state_d      = StDown;
                     end else
`endif
                     if (repeat_q) begin
                        phi_inc_d    = start_q;
                        step_pulse_d = 1'b1;
                     end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                     end
                  end else begin
                     cnt_d = cnt_q - DWELL_W'(1);
                  end
               end
            end

`ifdef SWEEP_TRIANGLE_EN
            StDown: begin
               if (clken) begin
                  if (hold_end) begin
                     cnt_d = dwell_q;
                     if (phi_inc_q != start_q) begin
                        phi_inc_d    = dn_next;
                        step_pulse_d = 1'b1;
                     end else if (repeat_q) begin
                        // phi_inc_q equals start here, so up_next is start+step clamped.
                        phi_inc_d    = up_next;
                        step_pulse_d = 1'b1;
                        state_d      = StRun;
                     end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                     end
                  end else begin
                     cnt_d = cnt_q - DWELL_W'(1);
                  end
               end
            end
`endif

            StDone: begin
               state_d = StIdle;
            end

            default: begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         phi_inc_q    <= '0;
         start_q      <= '0;
         stop_q       <= '0;
         step_q       <= '0;
         repeat_q     <= 1'b0;
         dwell_q      <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         step_pulse_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
         tri_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         phi_inc_q    <= phi_inc_d;
         start_q      <= start_d;
         stop_q       <= stop_d;
         step_q       <= step_d;
         repeat_q     <= repeat_d;
         dwell_q      <= dwell_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         step_pulse_q <= step_pulse_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef SWEEP_TRIANGLE_EN
         tri_q        <= tri_d;
`endif
      end
   end

   assign phi_inc_o = phi_inc_q;
   assign busy_o    = busy_q;
   assign step_o    = step_pulse_q;
   assign done_o    = done_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl. Inputs change 1 ns after a rising edge.
// Outputs are sampled on the falling edge.
module tb_nco_sweep_ctrl;

   logic        clk;
   logic        reset_n;
   logic        clken;
   logic        start_i;
   logic        abort_i;
   logic        repeat_i;
`ifdef SWEEP_TRIANGLE_EN
   logic        tri_i;
`endif
   logic [31:0] phi_start_i;
   logic [31:0] phi_stop_i;
   logic [31:0] phi_step_i;
   logic [15:0] dwell_i;
   logic [31:0] phi_inc_o;
   logic        busy_o;
   logic        step_o;
   logic        done_o;
   logic        err_o;

   int n_checks = 0;
   int n_fail   = 0;

   nco_sweep_ctrl #(
      .PHW     (32),
      .DWELL_W (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clken       (clken),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .repeat_i    (repeat_i),
`ifdef SWEEP_TRIANGLE_EN
      .tri_i       (tri_i),
`endif
      .phi_start_i (phi_start_i),
      .phi_stop_i  (phi_stop_i),
      .phi_step_i  (phi_step_i),
      .dwell_i     (dwell_i),
      .phi_inc_o   (phi_inc_o),
      .busy_o      (busy_o),
      .step_o      (step_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Start request aligned to a clock edge; returns 1 ns after the accepting edge.
   task automatic pulse_start(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                              input logic [15:0] d, input logic r);
      @(posedge clk);
      #1;
      phi_start_i = s;
      phi_stop_i  = e;
      phi_step_i  = st;
      dwell_i     = d;
      repeat_i    = r;
      start_i     = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (phi_inc_o !== 32'd0) begin
         n_fail++; $display("FAIL reset_phi got %0h exp 0", phi_inc_o);
      end
      n_checks++;
      if ({busy_o, step_o, done_o, err_o} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy_o, step_o, done_o, err_o});
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_ramp();
      int steps;
      logic [31:0] exp_phi;
      steps = 0;
      pulse_start(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         exp_phi = 32'd100 + 32'd10 * 32'(c / 3);
         if (step_o === 1'b1) steps++;
         n_checks++;
         if (phi_inc_o !== exp_phi || step_o !== (c % 3 == 0) || busy_o !== 1'b1 ||
             done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp c=%0d got phi=%0d step=%b busy=%b done=%b exp phi=%0d step=%b 1 0",
                     c, phi_inc_o, step_o, busy_o, done_o, exp_phi, (c % 3 == 0));
         end
      end
      n_checks++;
      if (steps != 4) begin
         n_fail++; $display("FAIL ramp_step_count got %0d exp 4", steps);
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'd130 || step_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ramp_done got done=%b busy=%b phi=%0d step=%b exp 1 0 130 0",
                  done_o, busy_o, phi_inc_o, step_o);
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || phi_inc_o !== 32'd130) begin
         n_fail++;
         $display("FAIL ramp_after got done=%b busy=%b phi=%0d exp 0 0 130",
                  done_o, busy_o, phi_inc_o);
      end
   endtask

   task automatic test_carry();
      pulse_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (phi_inc_o !== 32'hFFFF_FFF0 || step_o !== 1'b1) begin
         n_fail++; $display("FAIL carry_first got %h step=%b exp fffffff0 1", phi_inc_o, step_o);
      end
      @(negedge clk);
      n_checks++;
      if (phi_inc_o !== 32'hFFFF_FFFF || step_o !== 1'b1 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL carry_clamp got %h step=%b busy=%b exp ffffffff 1 1",
                  phi_inc_o, step_o, busy_o);
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL carry_done got done=%b busy=%b phi=%h exp 1 0 ffffffff",
                  done_o, busy_o, phi_inc_o);
      end
   endtask

   task automatic test_repeat_abort();
      logic [31:0] exp_phi;
      pulse_start(32'd5, 32'd9, 32'd4, 16'd0, 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp_phi = (c % 2 == 0) ? 32'd5 : 32'd9;
         n_checks++;
         if (phi_inc_o !== exp_phi || step_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat c=%0d got phi=%0d step=%b busy=%b done=%b exp phi=%0d 1 1 0",
                     c, phi_inc_o, step_o, busy_o, done_o, exp_phi);
         end
      end
      // Still in the 9 hold here; abort takes effect on the next edge.
      abort_i = 1'b1;
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (phi_inc_o !== 32'd9 || busy_o !== 1'b0 || step_o !== 1'b0 || done_o !== 1'b0 ||
          err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort got phi=%0d busy=%b step=%b done=%b err=%b exp 9 0 0 0 0",
                  phi_inc_o, busy_o, step_o, done_o, err_o);
      end
      // Abort together with a valid start: abort wins.
      @(posedge clk);
      #1;
      phi_start_i = 32'd40; phi_stop_i = 32'd50; phi_step_i = 32'd5; dwell_i = 16'd1;
      start_i = 1'b1; abort_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0; abort_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (phi_inc_o !== 32'd9 || busy_o !== 1'b0 || step_o !== 1'b0 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_start got phi=%0d busy=%b step=%b err=%b exp 9 0 0 0",
                  phi_inc_o, busy_o, step_o, err_o);
      end
   endtask

   task automatic test_errors();
      logic [31:0] exp_phi;
      pulse_start(32'd10, 32'd20, 32'd0, 16'd1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'd9 || step_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_step0 got err=%b busy=%b phi=%0d step=%b exp 1 0 9 0",
                  err_o, busy_o, phi_inc_o, step_o);
      end
      @(negedge clk);
      n_checks++;
      if (err_o !== 1'b0) begin
         n_fail++; $display("FAIL err_pulse_width got %b exp 0", err_o);
      end
      pulse_start(32'd200, 32'd100, 32'd1, 16'd1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'd9) begin
         n_fail++;
         $display("FAIL err_order got err=%b busy=%b phi=%0d exp 1 0 9", err_o, busy_o, phi_inc_o);
      end
      // Valid run; a second start and new config inputs mid-run must be ignored.
      pulse_start(32'd50, 32'd80, 32'd10, 16'd2, 1'b0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_phi = 32'd50 + 32'd10 * 32'(c / 2);
         n_checks++;
         if (phi_inc_o !== exp_phi || step_o !== (c % 2 == 0) || busy_o !== 1'b1 ||
             err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ignore c=%0d got phi=%0d step=%b busy=%b err=%b exp phi=%0d",
                     c, phi_inc_o, step_o, busy_o, err_o, exp_phi);
         end
         if (c == 0) begin
            phi_start_i = 32'd1000; phi_stop_i = 32'd2000; phi_step_i = 32'd1; dwell_i = 16'd9;
            repeat_i = 1'b1;
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
         end
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'd80) begin
         n_fail++;
         $display("FAIL run_ignore_done got done=%b busy=%b phi=%0d exp 1 0 80",
                  done_o, busy_o, phi_inc_o);
      end
   endtask

   task automatic test_single_point();
      pulse_start(32'd77, 32'd77, 32'd5, 16'd2, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (phi_inc_o !== 32'd77 || step_o !== (c == 0) || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single c=%0d got phi=%0d step=%b busy=%b done=%b exp 77",
                     c, phi_inc_o, step_o, busy_o, done_o);
         end
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'd77) begin
         n_fail++;
         $display("FAIL single_done got done=%b busy=%b phi=%0d exp 1 0 77",
                  done_o, busy_o, phi_inc_o);
      end
   endtask

   task automatic test_clken_reset();
      logic [31:0] exp_phi;
      clken = 1'b1;
      pulse_start(32'd300, 32'd320, 32'd10, 16'd2, 1'b0);
      for (int c = 0; c < 12; c++) begin
         clken = (c % 2 == 1);
         @(negedge clk);
         exp_phi = 32'd300 + 32'd10 * 32'(c / 4);
         n_checks++;
         if (phi_inc_o !== exp_phi || step_o !== (c % 4 == 0) || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clken c=%0d got phi=%0d step=%b busy=%b exp phi=%0d step=%b busy=1",
                     c, phi_inc_o, step_o, busy_o, exp_phi, (c % 4 == 0));
         end
         if (c == 5) begin
            reset_n = 1'b0;
            #1;
            n_checks++;
            if (phi_inc_o !== 32'd0 || busy_o !== 1'b0) begin
               n_fail++;
               $display("FAIL async_reset got phi=%0d busy=%b exp 0 0", phi_inc_o, busy_o);
            end
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clken   = 1'b1;
      @(negedge clk);
      n_checks++;
      if (phi_inc_o !== 32'd0 || busy_o !== 1'b0 || step_o !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset got phi=%0d busy=%b step=%b exp 0 0 0", phi_inc_o, busy_o, step_o);
      end
   endtask

`ifdef SWEEP_TRIANGLE_EN
   task automatic test_triangle();
      logic [31:0] exp_seq [5];
      exp_seq[0] = 32'd0; exp_seq[1] = 32'd10; exp_seq[2] = 32'd20;
      exp_seq[3] = 32'd10; exp_seq[4] = 32'd0;
      tri_i = 1'b1;
      pulse_start(32'd0, 32'd20, 32'd10, 16'd1, 1'b0);
      tri_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (phi_inc_o !== exp_seq[c] || step_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tri c=%0d got phi=%0d step=%b busy=%b done=%b exp phi=%0d",
                     c, phi_inc_o, step_o, busy_o, done_o, exp_seq[c]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || phi_inc_o !== 32'd0) begin
         n_fail++;
         $display("FAIL tri_done got done=%b busy=%b phi=%0d exp 1 0 0", done_o, busy_o, phi_inc_o);
      end
   endtask
`endif

   initial begin
      reset_n     = 1'b0;
      clken       = 1'b1;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      repeat_i    = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      tri_i       = 1'b0;
`endif
      phi_start_i = '0;
      phi_stop_i  = '0;
      phi_step_i  = '0;
      dwell_i     = '0;

      test_reset();
      test_ramp();
      test_carry();
      test_repeat_abort();
      test_errors();
      test_single_point();
      test_clken_reset();
`ifdef SWEEP_TRIANGLE_EN
      test_triangle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
